// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: FSM states,
// winner codes and the eight winning line masks of the 3x3 board
// (squares numbered 0..8 row-major).
package gato_pkg;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    EVALUA = 2'd1,
    FIN    = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    NINGUNO = 2'b00,
    P1      = 2'b01,
    P2      = 2'b10,
    EMPATE  = 2'b11
  } ganador_t;

  localparam int unsigned NUM_LINEAS   = 8;
  localparam logic [8:0]  TABLERO_LLENO = 9'h1FF;

  // Index 0..2 rows, 3..5 columns, 6 main diagonal, 7 anti-diagonal.
  localparam logic [NUM_LINEAS-1:0][8:0] LINEAS = {
    9'h054,  // 2,4,6
    9'h111,  // 0,4,8
    9'h124,  // 2,5,8
    9'h092,  // 1,4,7
    9'h049,  // 0,3,6
    9'h1C0,  // 6,7,8
    9'h038,  // 3,4,5
    9'h007   // 0,1,2
  };

  // Square indices 9..15 from the selector do not exist on the board.
  function automatic logic cuadro_valido(input logic [3:0] cuadro);
    return (cuadro <= 4'd8);
  endfunction

endpackage

// File: rtl/detector_linea.sv
// Flags whether a 9-bit board owns every square of at least one of the
// eight winning lines. Purely combinational.
module detector_linea
  import gato_pkg::*;
(
  input  logic [8:0] tablero_i,
  output logic       linea_o
);

  // OR-reduce the "line fully covered" test over all eight masks
  always_comb begin
    linea_o = 1'b0;
    for (int i = 0; i < NUM_LINEAS; i++) begin
      if ((tablero_i & LINEAS[i]) == LINEAS[i]) begin
        linea_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_turnos.sv
// Two-player tic-tac-toe turn controller. A move is accepted in ESPERA,
// judged for one cycle in EVALUA, and the game parks in FIN once someone
// wins or the board fills up.
//
// Optional feature: define TIMEOUT_TURNO_EN to build in the per-turn timer
// (TIEMPO_TURNO cycles of idleness in ESPERA forfeit the turn). Without it
// turno_perdido is constant 0 and TIEMPO_TURNO has no effect.
module controlador_turnos
  import gato_pkg::*;
#(
  parameter int unsigned TIEMPO_TURNO = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       elige,
  input  logic [3:0] cuadro,
  input  logic       reinicio,
  output logic       turno_p1,
  output logic [8:0] tablero_p1,
  output logic [8:0] tablero_p2,
  output logic [1:0] ganador,
  output logic       fin_juego,
  output logic       rechazo,
  output logic       turno_perdido
);

  estado_t    estado_q,  estado_d;
  logic       turno_q,   turno_d;
  logic [8:0] tab1_q,    tab1_d;
  logic [8:0] tab2_q,    tab2_d;
  ganador_t   ganador_q, ganador_d;
  logic       rechazo_q, rechazo_d;

  logic [8:0] ocupado;
  logic [8:0] mascara_cuadro;
  logic [8:0] tablero_mover;
  logic       acepta;
  logic       hay_linea;
  logic       vence;

  // Shifting past bit 8 yields zero, so invalid squares never match.
  assign ocupado        = tab1_q | tab2_q;
  assign mascara_cuadro = 9'b1 << cuadro;
  assign acepta         = elige && cuadro_valido(cuadro) &&
                          ((ocupado & mascara_cuadro) == 9'b0);

  // In EVALUA the board of the player who just moved already holds the
  // new square, and turno_q still names that player.
  assign tablero_mover = turno_q ? tab1_q : tab2_q;

  detector_linea u_detector_linea (
    .tablero_i (tablero_mover),
    .linea_o   (hay_linea)
  );

`ifdef TIMEOUT_TURNO_EN
  localparam int unsigned      CNT_W   = (TIEMPO_TURNO > 1) ? $clog2(TIEMPO_TURNO) : 1;
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(TIEMPO_TURNO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perdido_q;

  // A pending elige (even a rejected one) holds off the forfeit.
  assign vence = (estado_q == ESPERA) && !elige && (cnt_q == CNT_FIN);

  // Turn timer: counts ESPERA cycles, saturates at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (reinicio) begin
      cnt_d = '0;
    end else if (estado_q == ESPERA) begin
      if (acepta || vence) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_FIN) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Timer register and the one-cycle forfeit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      perdido_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      perdido_q <= vence && !reinicio;
    end
  end

  assign turno_perdido = perdido_q;
`else
  assign vence         = 1'b0;
  assign turno_perdido = 1'b0;
`endif

  // Next-state and next-output logic of the game FSM
  always_comb begin
    estado_d  = estado_q;
    turno_d   = turno_q;
    tab1_d    = tab1_q;
    tab2_d    = tab2_q;
    ganador_d = ganador_q;
    rechazo_d = 1'b0;

    if (reinicio) begin
      estado_d  = ESPERA;
      turno_d   = 1'b1;
      tab1_d    = 9'b0;
      tab2_d    = 9'b0;
      ganador_d = NINGUNO;
    end else begin
      case (estado_q)
        ESPERA: begin
          if (elige) begin
            if (acepta) begin
              if (turno_q) begin
                tab1_d = tab1_q | mascara_cuadro;
              end else begin
                tab2_d = tab2_q | mascara_cuadro;
              end
              estado_d = EVALUA;
            end else begin
              rechazo_d = 1'b1;
            end
          end else if (vence) begin
            turno_d = ~turno_q;
          end
        end
        EVALUA: begin
          // A line is checked before fullness so a ninth-move win counts.
          if (hay_linea) begin
            ganador_d = turno_q ? P1 : P2;
            estado_d  = FIN;
          end else if (ocupado == TABLERO_LLENO) begin
            ganador_d = EMPATE;
            estado_d  = FIN;
          end else begin
            turno_d  = ~turno_q;
            estado_d = ESPERA;
          end
        end
        FIN: begin
          estado_d = FIN;
        end
        default: begin
          estado_d = ESPERA;
        end
      endcase
    end
  end

  // Game FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= ESPERA;
      turno_q   <= 1'b1;
      tab1_q    <= 9'b0;
      tab2_q    <= 9'b0;
      ganador_q <= NINGUNO;
      rechazo_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      turno_q   <= turno_d;
      tab1_q    <= tab1_d;
      tab2_q    <= tab2_d;
      ganador_q <= ganador_d;
      rechazo_q <= rechazo_d;
    end
  end

  assign turno_p1   = turno_q;
  assign tablero_p1 = tab1_q;
  assign tablero_p2 = tab2_q;
  assign ganador    = ganador_q;
  assign fin_juego  = (estado_q == FIN);
  assign rechazo    = rechazo_q;

endmodule

// File: tb/tb_controlador_turnos.sv
// Bench for controlador_turnos: a square-ownership game model stepped on
// every clock edge, compared against the DUT on every falling edge, plus
// literal expectations on the directed scenarios.
`timescale 1ns/1ps
module tb_controlador_turnos;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       elige;
  logic [3:0] cuadro;
  logic       reinicio;
  logic       turno_p1;
  logic [8:0] tablero_p1;
  logic [8:0] tablero_p2;
  logic [1:0] ganador;
  logic       fin_juego;
  logic       rechazo;
  logic       turno_perdido;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  controlador_turnos #(.TIEMPO_TURNO(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .elige         (elige),
    .cuadro        (cuadro),
    .reinicio      (reinicio),
    .turno_p1      (turno_p1),
    .tablero_p1    (tablero_p1),
    .tablero_p2    (tablero_p2),
    .ganador       (ganador),
    .fin_juego     (fin_juego),
    .rechazo       (rechazo),
    .turno_perdido (turno_perdido)
  );

  // ---------------- game model ----------------
  int m_dueno[9];   // 0 free, 1 player 1, 2 player 2
  int m_turno;      // 1 or 2
  int m_gan;        // 0 none, 1, 2, 3 draw
  int m_cnt;        // idle cycles in the current turn
  bit m_pend;       // a move waits to be judged
  bit m_fin;
  bit m_rech;
  bit m_perd;

  function automatic bit gana(input int p);
    bit r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_dueno[3*k] == p && m_dueno[3*k+1] == p && m_dueno[3*k+2] == p) r = 1'b1;
      if (m_dueno[k] == p && m_dueno[k+3] == p && m_dueno[k+6] == p) r = 1'b1;
    end
    if (m_dueno[0] == p && m_dueno[4] == p && m_dueno[8] == p) r = 1'b1;
    if (m_dueno[2] == p && m_dueno[4] == p && m_dueno[6] == p) r = 1'b1;
    return r;
  endfunction

  function automatic bit lleno();
    bit r = 1'b1;
    for (int k = 0; k < 9; k++) if (m_dueno[k] == 0) r = 1'b0;
    return r;
  endfunction

  function automatic logic [8:0] m_tab(input int p);
    logic [8:0] b = 9'b0;
    for (int k = 0; k < 9; k++) if (m_dueno[k] == p) b[k] = 1'b1;
    return b;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 9; k++) m_dueno[k] = 0;
    m_turno = 1; m_gan = 0; m_cnt = 0;
    m_pend = 1'b0; m_fin = 1'b0; m_rech = 1'b0; m_perd = 1'b0;
  endtask

  task automatic m_paso();
    m_rech = 1'b0;
    m_perd = 1'b0;
    if (reinicio) begin
      for (int k = 0; k < 9; k++) m_dueno[k] = 0;
      m_turno = 1; m_gan = 0; m_cnt = 0; m_pend = 1'b0; m_fin = 1'b0;
    end else if (m_pend) begin
      m_pend = 1'b0;
      if (gana(m_turno)) begin
        m_gan = m_turno; m_fin = 1'b1;
      end else if (lleno()) begin
        m_gan = 3; m_fin = 1'b1;
      end else begin
        m_turno = 3 - m_turno;
      end
    end else if (!m_fin) begin
      if (elige && cuadro <= 4'd8 && m_dueno[cuadro] == 0) begin
        m_dueno[cuadro] = m_turno;
        m_pend = 1'b1;
        m_cnt = 0;
      end else begin
        if (elige) m_rech = 1'b1;
`ifdef TIMEOUT_TURNO_EN
        if (!elige && m_cnt == T - 1) begin
          m_turno = 3 - m_turno; m_perd = 1'b1; m_cnt = 0;
        end else if (m_cnt < T - 1) begin
          m_cnt++;
        end
`endif
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_paso();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nombre, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nombre, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("m.turno_p1",      9'(turno_p1),      9'(m_turno == 1));
      chk("m.tablero_p1",    tablero_p1,        m_tab(1));
      chk("m.tablero_p2",    tablero_p2,        m_tab(2));
      chk("m.ganador",       9'(ganador),       9'(m_gan));
      chk("m.fin_juego",     9'(fin_juego),     9'(m_fin));
      chk("m.rechazo",       9'(rechazo),       9'(m_rech));
      chk("m.turno_perdido", 9'(turno_perdido), 9'(m_perd));
      chk("m.exclusion",     tablero_p1 & tablero_p2, 9'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic jugar(input int c);
    elige = 1'b1;
    cuadro = 4'(c);
    ciclo();
    elige = 1'b0;
    ciclo();
  endtask

  task automatic reiniciar();
    reinicio = 1'b1;
    ciclo();
    reinicio = 1'b0;
  endtask

  int seq_gana_p1[5]   = '{0, 3, 1, 4, 2};
  int seq_empate[9]    = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int seq_gana_nov[9]  = '{0, 1, 2, 3, 5, 7, 6, 8, 4};

  initial begin
    rst_n = 1'b0; elige = 1'b0; reinicio = 1'b0; cuadro = 4'd0;
    #12;
    chk("rst.turno_p1",   9'(turno_p1),  9'h001);
    chk("rst.tablero_p1", tablero_p1,    9'h000);
    chk("rst.tablero_p2", tablero_p2,    9'h000);
    chk("rst.ganador",    9'(ganador),   9'h000);
    chk("rst.fin_juego",  9'(fin_juego), 9'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first move right after reset release
    elige = 1'b1; cuadro = 4'd4;
    ciclo();
    chk("m1.tablero_p1", tablero_p1,   9'h010);
    chk("m1.turno_same", 9'(turno_p1), 9'h001);
    elige = 1'b0;
    ciclo();
    chk("m1.turno_p2",   9'(turno_p1), 9'h000);

    // occupied square and invalid index
    reiniciar();
    jugar(0);
    elige = 1'b1; cuadro = 4'd0;
    ciclo();
    chk("occ.rechazo",    9'(rechazo),   9'h001);
    chk("occ.tablero_p2", tablero_p2,    9'h000);
    chk("occ.tablero_p1", tablero_p1,    9'h001);
    elige = 1'b0;
    ciclo();
    chk("occ.rechazo_off", 9'(rechazo),  9'h000);
    chk("occ.turno",       9'(turno_p1), 9'h000);
    elige = 1'b1; cuadro = 4'd12;
    ciclo();
    chk("inv.rechazo",    9'(rechazo),   9'h001);
    chk("inv.tablero_p2", tablero_p2,    9'h000);
    elige = 1'b0;
    ciclo();
    chk("inv.turno",      9'(turno_p1),  9'h000);

    // player 1 wins the top row
    reiniciar();
    foreach (seq_gana_p1[i]) jugar(seq_gana_p1[i]);
    chk("win.ganador",   9'(ganador),   9'h001);
    chk("win.fin_juego", 9'(fin_juego), 9'h001);
    chk("win.tablero_p1", tablero_p1,   9'h007);
    elige = 1'b1; cuadro = 4'd8;
    ciclo();
    chk("fin.no_rechazo", 9'(rechazo),  9'h000);
    chk("fin.tablero_p2", tablero_p2,   9'h018);
    elige = 1'b0;
    ciclo();
    // reinicio beats a simultaneous elige
    reinicio = 1'b1; elige = 1'b1; cuadro = 4'd5;
    ciclo();
    chk("rei.tablero_p1", tablero_p1,   9'h000);
    chk("rei.tablero_p2", tablero_p2,   9'h000);
    chk("rei.turno",      9'(turno_p1), 9'h001);
    chk("rei.ganador",    9'(ganador),  9'h000);
    chk("rei.fin",        9'(fin_juego), 9'h000);
    reinicio = 1'b0; elige = 1'b0;
    ciclo();

    // full board without a line
    reiniciar();
    foreach (seq_empate[i]) jugar(seq_empate[i]);
    chk("draw.ganador",   9'(ganador),   9'h003);
    chk("draw.fin_juego", 9'(fin_juego), 9'h001);

    // line completed by the ninth move
    reiniciar();
    foreach (seq_gana_nov[i]) jugar(seq_gana_nov[i]);
    chk("win9.ganador",   9'(ganador),   9'h001);
    chk("win9.tablero_p1", tablero_p1,   9'h075);

    // asynchronous reset while a move is being judged
    reiniciar();
    jugar(0);
    elige = 1'b1; cuadro = 4'd4;
    ciclo();
    elige = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.tablero_p1", tablero_p1,   9'h000);
    chk("arst.tablero_p2", tablero_p2,   9'h000);
    chk("arst.turno",      9'(turno_p1), 9'h001);
    chk("arst.ganador",    9'(ganador),  9'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    jugar(2);
    chk("arst.move_after", tablero_p1,   9'h004);
    chk("arst.turno_p2",   9'(turno_p1), 9'h000);

`ifdef TIMEOUT_TURNO_EN
    // idle turn forfeits, then a move on the terminal cycle wins
    reiniciar();
    repeat (T - 1) begin
      ciclo();
      chk("to.no_pulse", 9'(turno_perdido), 9'h000);
    end
    ciclo();
    chk("to.pulse", 9'(turno_perdido), 9'h001);
    chk("to.turno", 9'(turno_p1),      9'h000);
    ciclo();
    chk("to.pulse_off", 9'(turno_perdido), 9'h000);
    repeat (T - 2) ciclo();
    elige = 1'b1; cuadro = 4'd0;
    ciclo();
    chk("to.move_wins", 9'(turno_perdido), 9'h000);
    chk("to.tablero_p2", tablero_p2,       9'h001);
    elige = 1'b0;
    ciclo();
    chk("to.turno_back", 9'(turno_p1), 9'h001);
`endif

    ciclo();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controlador_turnos.md
CONTROLADOR_TURNOS -- requirements
Module: controlador_turnos

Interface
REQ-001 Parameter TIEMPO_TURNO, default 50_000_000, meaning clock cycles allowed per turn before forfeit (used only with REQ-030).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 elige  input  1  single-cycle pulse, current player confirms square.
REQ-005 cuadro  input  4  square index from the square selector, 0..8 row-major, 9..15 invalid.
REQ-006 reinicio  input  1  synchronous new-game request, level-sampled.
REQ-007 turno_p1  output  1  1 = player 1 to move, 0 = player 2 to move.
REQ-008 tablero_p1  output  9  squares owned by player 1, bit i = square i.
REQ-009 tablero_p2  output  9  squares owned by player 2.
REQ-010 ganador  output  2  00 none, 01 player 1, 10 player 2, 11 draw.
REQ-011 fin_juego  output  1  high while the game is over.
REQ-012 rechazo  output  1  one-cycle pulse, selection rejected.
REQ-013 turno_perdido  output  1  one-cycle pulse, turn forfeited by timeout.

Function
REQ-014 FSM states SHALL be ESPERA, EVALUA, FIN.
REQ-015 ESPERA, elige=1, cuadro<=8, square free in both boards: set bit cuadro in the current player's board at that edge, go to EVALUA.
REQ-016 ESPERA, elige=1, cuadro>8 or square occupied: boards unchanged, rechazo=1 for the next cycle only, stay in ESPERA, turn unchanged.
REQ-017 EVALUA lasts exactly one cycle: mover owns any of the 8 lines (3 rows, 3 columns, 2 diagonals) -> ganador = mover code, go to FIN; else if all 9 squares are owned -> ganador=11, go to FIN; else toggle turno_p1, go to ESPERA.
REQ-018 A win on the ninth move SHALL report the winner, not a draw.
REQ-019 Latency: accepted elige at edge N -> board bit visible after N; ganador/fin_juego or toggled turno_p1 visible after N+1.
REQ-020 elige in EVALUA or FIN SHALL be ignored, with no rechazo.
REQ-021 fin_juego SHALL be 1 exactly when state is FIN.
REQ-022 reinicio=1 in any state SHALL, at the next edge, clear both boards, ganador=00, turno_p1=1, the timeout counter, and go to ESPERA; reinicio has priority over elige.
REQ-023 tablero_p1 AND tablero_p2 SHALL always be zero.

Reset
REQ-024 rst_n low SHALL asynchronously force state ESPERA, turno_p1=1, tablero_p1=0, tablero_p2=0, ganador=00, rechazo=0, turno_perdido=0, timeout counter 0.
REQ-025 The first edge after rst_n deasserts SHALL be a normal ESPERA cycle.
REQ-026 Reset asserted mid-EVALUA SHALL discard the pending evaluation.

Configuration
REQ-027 Macro TIMEOUT_TURNO_EN SHALL compile the turn timer in or out.
REQ-028 With TIMEOUT_TURNO_EN: a counter increments every cycle in ESPERA and clears on an accepted move, reinicio, or forfeit.
REQ-029 Counter width SHALL be $clog2(TIEMPO_TURNO) bits with no wrap before terminal count.
REQ-030 With TIMEOUT_TURNO_EN: counter = TIEMPO_TURNO-1 in ESPERA with no elige -> toggle turno_p1, pulse turno_perdido for one cycle, boards unchanged.
REQ-031 Accepted elige and timeout in the same cycle: the move wins, no forfeit.
REQ-032 Without TIMEOUT_TURNO_EN: no counter logic, turno_perdido tied 0, TIEMPO_TURNO unused.

Structure
REQ-033 Shared package gato_pkg SHALL hold the state enum, ganador codes (NINGUNO, P1, P2, EMPATE) and the 8 nine-bit line masks.
REQ-034 Sub-module detector_linea SHALL combinationally flag whether a 9-bit board covers any line mask, instantiated once on the mover's board.

Verification
REQ-035 Reset, then elige with cuadro=4 -> tablero_p1=0x010, then turno_p1=0 two edges after elige.
REQ-036 P1 takes 0, P2 takes 0 -> rechazo pulses once, tablero_p2=0, turno_p1 stays 0; cuadro=12 -> rechazo, no change.
REQ-037 P1 plays 0,1,2 and P2 plays 3,4 -> ganador=01, fin_juego=1; then elige is ignored; then reinicio -> all cleared, turno_p1=1.
REQ-038 Moves 0,1,2,4,3,5,7,6,8 alternating from P1 -> after 9th move ganador=11, fin_juego=1.
REQ-039 TIEMPO_TURNO=8 with TIMEOUT_TURNO_EN: idle 8 cycles -> turno_perdido pulse, turno_p1=0; elige on cycle 8 -> move accepted, no pulse.
REQ-040 rst_n low mid-game between clock edges -> outputs reach reset values before the next edge.
